timer_counter: RTL and testbench

Memory-mapped timer/counter peripheral hanging off the CPU data bus. It accepts word-aligned stores/loads from the processor's memory stage and drives the external interrupt line into the CPU. Software programs a preset, enables counting, and receives an interrupt on expiry, either one-shot or periodic. Base address 0x0000_7F00, occupying a 16-byte window.

---
 rtl/timer_counter_if.sv | 17 +
 rtl/timer_counter.sv | 67 ++++++
 tb/tb_timer_counter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_if.sv
// timer_counter_if: CPU data-bus port of the timer peripheral.
//   addr    byte address from the CPU (bits [1:0] ignored)
//   we      write strobe
//   byteen  per-byte write enables, bit3 = [31:24]
//   wdata   store data
//   rdata   combinational read data
//   irq     interrupt request to the CPU
interface timer_counter_if;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    modport master (output addr, we, byteen, wdata, input rdata, irq);
    modport slave (input addr, we, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped one-shot / auto-reload timer with interrupt.
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    slave side of timer_counter_if (CTRL, PRESET, COUNT, reserved)
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input logic            clk,
    input logic            reset,
    timer_counter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CNT, INT} state_t;
    state_t      state;
    logic        en, im, flag, irq_q;
    logic [1:0]  mode, off;
    logic [31:0] preset, count;
    logic        hit, ctrl_wr, ctrl_b0, preset_wr, reload, expire, flag_nxt, im_nxt;
    logic        unused;
    assign unused = ^bus.addr[1:0];
    always_comb begin
        off       = bus.addr[3:2];
        hit       = bus.addr[31:4] == BASE_ADDR[31:4];
        ctrl_wr   = hit && bus.we && |bus.byteen && off == 2'd0;
        ctrl_b0   = ctrl_wr && bus.byteen[0];
        preset_wr = hit && bus.we && off == 2'd1;
        reload    = mode == 2'b01;
        expire    = state == CNT && en && count == '0;
        // an expiry on the same edge as a CTRL write must not be lost
        flag_nxt  = expire ? 1'b1 : ctrl_wr ? 1'b0 : (state == INT && reload) ? 1'b0 : flag;
        im_nxt    = ctrl_b0 ? bus.wdata[3] : im;
        bus.rdata = !hit ? '0 : off == 2'd0 ? {28'b0, im, mode, en} : off == 2'd1 ? preset :
                    off == 2'd2 ? count : '0;
    end
    assign bus.irq = irq_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            en     <= 1'b0;
            mode   <= 2'b00;
            im     <= 1'b0;
            preset <= '0;
            count  <= '0;
            flag   <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: if (!en) state <= IDLE;
                    else if (count != '0) count <= count - 32'd1;
                    else state <= INT;
                default: begin
                    state <= IDLE;
                    if (!reload) en <= 1'b0;
                end
            endcase
            // placed after the FSM so a bus write of EN overrides the one-shot clear
            if (ctrl_b0) {im, mode, en} <= bus.wdata[3:0];
            for (int i = 0; i < 4; i++)
                if (preset_wr && bus.byteen[i]) preset[8*i +: 8] <= bus.wdata[8*i +: 8];
            flag  <= flag_nxt;
            irq_q <= flag_nxt & im_nxt;
        end
    end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: randomized and directed checks of timer_counter against a timeline model.
module tb_timer_counter;
    localparam logic [31:0] B = 32'h0000_7F00;
    logic clk = 1'b0;
    logic reset = 1'b0;
    timer_counter_if bus();
    timer_counter #(.BASE_ADDR(B)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    logic        m_en, m_im, m_flag, m_irq, m_run, m_int;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_cnt, m_ld;
    longint      m_age;
    int          pulses[$];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:4] != B[31:4]) return '0;
        case (a[3:2])
            2'd0: return {28'b0, m_im, m_mode, m_en};
            2'd1: return m_preset;
            2'd2: return m_cnt;
            default: return '0;
        endcase
    endfunction
    task automatic model_reset();
        {m_en, m_im, m_flag, m_irq, m_run, m_int} = '0;
        m_mode = '0;
        m_preset = '0;
        m_cnt = '0;
        m_ld = '0;
        m_age = 0;
    endtask
    // Timeline view: after a load the count is (loaded - age) and expiry happens at age loaded+1.
    task automatic model_step();
        logic cw, fset, fl, en_n;
        fset = 1'b0;
        fl = m_flag;
        en_n = m_en;
        if (m_int) begin
            m_int = 1'b0;
            if (m_mode == 2'b01) fl = 1'b0;
            else en_n = 1'b0;
        end else if (!m_run) begin
            if (m_en) begin
                m_run = 1'b1;
                m_age = 0;
                m_ld = m_preset;
                m_cnt = m_preset;
            end
        end else if (!m_en) m_run = 1'b0;
        else begin
            m_age++;
            if (m_age > longint'(m_ld)) begin
                m_run = 1'b0;
                m_int = 1'b1;
                fset = 1'b1;
            end else m_cnt = m_ld - 32'(m_age);
        end
        cw = bus.addr[31:4] == B[31:4] && bus.we && bus.byteen != 4'b0 && bus.addr[3:2] == 2'd0;
        if (cw && bus.byteen[0]) {m_im, m_mode, m_en} = bus.wdata[3:0];
        else m_en = en_n;
        if (bus.addr[31:4] == B[31:4] && bus.we && bus.addr[3:2] == 2'd1)
            for (int i = 0; i < 4; i++)
                if (bus.byteen[i]) m_preset[8*i +: 8] = bus.wdata[8*i +: 8];
        m_flag = fset | (fl & ~cw);
        m_irq = m_flag & m_im;
    endtask
    task automatic step(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] d);
        bus.addr = a;
        bus.we = w;
        bus.byteen = be;
        bus.wdata = d;
        @(posedge clk);
        if (reset) model_step();
        else model_reset();
        #1;
        check("irq", {31'b0, bus.irq}, {31'b0, m_irq});
        check("rdata", bus.rdata, m_read(bus.addr));
    endtask
    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] be);
        step(B + 32'(off), 1'b1, be, d);
    endtask
    task automatic rd(input int off);
        step(B + 32'(off), 1'b0, 4'b0, 32'b0);
    endtask
    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        rd(0);
        rd(0);
        reset = 1'b1;
    endtask
    task automatic wait_count(input logic [31:0] v, input string tag);
        int n = 0;
        rd(8);
        while (bus.rdata != v && n < 40) begin
            rd(8);
            n++;
        end
        check(tag, bus.rdata, v);
    endtask
    initial begin
        bus.addr = B;
        bus.we = 1'b0;
        bus.byteen = 4'b0;
        bus.wdata = '0;
        model_reset();
        #12;
        check("rst_irq", {31'b0, bus.irq}, 32'd0);
        for (int o = 0; o < 3; o++) begin
            bus.addr = B + 32'(4 * o);
            #1 check("rst_reg", bus.rdata, 32'd0);
        end
        reset = 1'b1;
        // one-shot
        wr(4, 32'd5, 4'hF);
        wr(0, 32'h9, 4'hF);
        for (int i = 0; i < 6; i++) begin
            rd(8);
            check("os_count", bus.rdata, 32'(5 - i));
        end
        rd(0);
        check("os_irq_set", {31'b0, bus.irq}, 32'd1);
        rd(0);
        check("os_ctrl_en_clr", bus.rdata, 32'h8);
        repeat (3) rd(0);
        check("os_irq_hold", {31'b0, bus.irq}, 32'd1);
        wr(0, 32'h8, 4'hF);
        check("os_irq_clr", {31'b0, bus.irq}, 32'd0);
        // auto-reload
        do_reset();
        wr(4, 32'd5, 4'hF);
        wr(0, 32'hB, 4'hF);
        for (int c = 0; c < 60; c++) begin
            rd(0);
            if (bus.irq) pulses.push_back(c);
        end
        check("ar_pulses", {31'b0, pulses.size() >= 4}, 32'd1);
        for (int i = 1; i < pulses.size(); i++) check("ar_period", 32'(pulses[i] - pulses[i-1]), 32'd8);
        check("ar_en", bus.rdata & 32'h1, 32'h1);
        // masking
        do_reset();
        wr(4, 32'd2, 4'hF);
        wr(0, 32'h1, 4'hF);
        repeat (8) rd(8);
        rd(0);
        check("mask_ctrl", bus.rdata, 32'h0);
        check("mask_irq", {31'b0, bus.irq}, 32'd0);
        wr(0, 32'h8, 4'h1);
        rd(0);
        check("mask_im_irq", {31'b0, bus.irq}, 32'd0);
        check("mask_im_ctrl", bus.rdata, 32'h8);
        // byte enables and decode
        do_reset();
        wr(4, 32'hAABB_CCDD, 4'b0101);
        rd(4);
        check("be_preset", bus.rdata, 32'h00BB_00DD);
        wr(8, 32'h1234_5678, 4'hF);
        step(B + 32'h10, 1'b1, 4'hF, 32'hFFFF_FFFF);
        rd(8);
        check("dec_count_ro", bus.rdata, 32'h0);
        rd(0);
        check("dec_alias_ctrl", bus.rdata, 32'h0);
        rd(4);
        check("dec_preset", bus.rdata, 32'h00BB_00DD);
        rd(12);
        check("dec_rsvd", bus.rdata, 32'h0);
        step(B + 32'h14, 1'b0, 4'h0, 32'h0);
        check("dec_miss", bus.rdata, 32'h0);
        // disable mid-count
        do_reset();
        wr(4, 32'd6, 4'hF);
        wr(0, 32'h1, 4'hF);
        wait_count(32'd3, "dis_wait");
        wr(0, 32'h0, 4'h1);
        repeat (3) rd(8);
        check("dis_frozen", bus.rdata, 32'd2);
        wr(0, 32'h1, 4'h1);
        rd(8);
        check("dis_reload", bus.rdata, 32'd6);
        // CTRL write on the expiry edge
        do_reset();
        wr(4, 32'd3, 4'hF);
        wr(0, 32'h9, 4'hF);
        repeat (4) rd(8);
        wr(0, 32'h9, 4'hF);
        check("race_irq", {31'b0, bus.irq}, 32'd1);
        // reset mid-count
        do_reset();
        wr(4, 32'd6, 4'hF);
        wr(0, 32'h9, 4'hF);
        wait_count(32'd3, "rst_wait");
        reset = 1'b0;
        model_reset();
        #1 check("rstm_irq", {31'b0, bus.irq}, 32'd0);
        for (int o = 0; o < 3; o++) begin
            bus.addr = B + 32'(4 * o);
            #1 check("rstm_reg", bus.rdata, 32'd0);
        end
        rd(8);
        reset = 1'b1;
        repeat (4) rd(8);
        check("rstm_count", bus.rdata, 32'd0);
        rd(0);
        check("rstm_ctrl", bus.rdata, 32'd0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r, o;
            logic [31:0] a, d;
            r = $urandom_range(0, 199);
            if (r < 2) begin
                reset = 1'b0;
                model_reset();
                #1 check("rand_rst_irq", {31'b0, bus.irq}, 32'd0);
            end else if (!reset && r > 100) reset = 1'b1;
            o = $urandom_range(0, 4);
            a = (o == 4) ? (($urandom_range(0, 1) == 1) ? B + 32'h10 : $urandom) : B + 32'(4 * o);
            d = (o == 0) ? 32'($urandom_range(0, 15)) : (o == 1 && $urandom_range(0, 7) != 0) ?
                32'($urandom_range(0, 9)) : $urandom;
            step(a, $urandom_range(0, 3) == 0, 4'($urandom), d);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
